alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one 16-bit ripple-carry ALU (AND/OR/ADD/SUB) behind a one-entry tagged result register.
// Latency: one cycle (accept at edge N, result visible after edge N); one operation per cycle with drain+accept on the same edge.
// Backpressure: req*_ready only when the result register is empty or being drained; held results stay stable. Tie policy: ALU_ARB_RR_EN (round-robin) else fixed priority to requester 0.
module alu_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [15:0] resp_o,
    output logic        resp_cout
);

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } alu_req_t;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;

    alu_req_t    req0, req1, sel;
    logic        last_grant;
    logic        can_accept;
    logic        tie_pick1;
    logic        grant0, grant1;
    logic        accept;

    logic        alu_sub;
    logic [15:0] b_eff;
    logic [15:0] sum;
    logic [16:0] carry;
    logic [15:0] alu_o;
    logic        alu_cout;

    assign req0 = '{op: req0_op, a: req0_a, b: req0_b};
    assign req1 = '{op: req1_op, a: req1_a, b: req1_b};

    // Result slot is free when empty or being drained on this edge.
    assign can_accept = !resp_valid || resp_ready;

    // Tie-break choice: round-robin alternates away from the last winner.
    always_comb begin
`ifdef ALU_ARB_RR_EN
        tie_pick1 = (last_grant == 1'b0);
`else
        tie_pick1 = 1'b0;
`endif
    end

    // Grant: a lone requester wins; a tie goes to the tie-break choice.
    always_comb begin
        grant1 = req1_valid && (!req0_valid || tie_pick1);
        grant0 = req0_valid && !grant1;
    end

    // No acceptance while reset is held, even though the slot looks empty.
    assign req0_ready = grant0 && can_accept && !reset;
    assign req1_ready = grant1 && can_accept && !reset;
    assign accept     = req0_ready || req1_ready;

    // Operand mux into the single shared ALU.
    assign sel = grant1 ? req1 : req0;

    // SUB is a + ~b + 1, sharing the adder with ADD.
    assign alu_sub  = (sel.op == 2'b11);
    assign b_eff    = alu_sub ? ~sel.b : sel.b;
    assign carry[0] = alu_sub;

    for (genvar i = 0; i < 16; i++) begin : g_rca
        assign sum[i]     = sel.a[i] ^ b_eff[i] ^ carry[i];
        assign carry[i+1] = (sel.a[i] & b_eff[i]) | (carry[i] & (sel.a[i] ^ b_eff[i]));
    end

    assign alu_cout = carry[16];

    // ALU result select.
    always_comb begin
        case (sel.op)
            OP_AND:  alu_o = sel.a & sel.b;
            OP_OR:   alu_o = sel.a | sel.b;
            default: alu_o = sum;
        endcase
    end

    // Result register: load on accept, clear valid on a bare drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_o     <= 16'h0000;
            resp_cout  <= 1'b0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_id    <= grant1;
            resp_o     <= alu_o;
            resp_cout  <= sel.op[1] ? alu_cout : 1'b0;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    // Last winner, updated only on an accepted transfer; reset so requester 0 takes the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else begin
            last_grant <= accept ? grant1 : last_grant;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vectors plus a per-cycle reference model.
// Latency: inputs driven 1 time unit after the rising edge, outputs compared on the falling edge.
// Backpressure: exercised with resp_ready held low for several cycles with a pending result.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp_valid, resp_ready, resp_id, resp_cout;
    logic [15:0] resp_o;

    int tests_run = 0;
    int tests_failed = 0;
    logic chk_en = 1'b0;

    alu_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_o(resp_o), .resp_cout(resp_cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result: plain 17-bit arithmetic, {cout, result}.
    function automatic logic [16:0] ref_alu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] r;
        case (op)
            2'b00:   r = {1'b0, a & b};
            2'b01:   r = {1'b0, a | b};
            2'b10:   r = {1'b0, a} + {1'b0, b};
            default: r = {(a >= b), a - b};
        endcase
        return r;
    endfunction

    // Model state: what the result register must hold, and who won last.
    logic        m_valid, m_id, m_cout, m_last;
    logic [15:0] m_o;
    logic        m_rr;
    logic        m_win1, m_any, m_room, m_acc;
    logic        e_r0, e_r1;
    logic [16:0] m_res;

`ifdef ALU_ARB_RR_EN
    assign m_rr = 1'b1;
`else
    assign m_rr = 1'b0;
`endif

    // Who should be served this cycle, and what readys must look like.
    always_comb begin
        m_any  = req0_valid || req1_valid;
        if (req0_valid && req1_valid)
            m_win1 = m_rr ? (m_last == 1'b0) : 1'b0;
        else
            m_win1 = req1_valid;
        m_room = (!m_valid || resp_ready) && !reset;
        m_acc  = m_any && m_room;
        e_r0   = m_acc && !m_win1;
        e_r1   = m_acc && m_win1;
        m_res  = m_win1 ? ref_alu(req1_op, req1_a, req1_b) : ref_alu(req0_op, req0_a, req0_b);
    end

    // Model state update.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0; m_id <= 1'b0; m_o <= 16'h0; m_cout <= 1'b0; m_last <= 1'b1;
        end else if (m_acc) begin
            m_valid <= 1'b1; m_id <= m_win1; m_o <= m_res[15:0]; m_cout <= m_res[16]; m_last <= m_win1;
        end else if (resp_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mdl_req0_ready", {31'd0, req0_ready}, {31'd0, e_r0});
            chk("mdl_req1_ready", {31'd0, req1_ready}, {31'd0, e_r1});
            chk("mdl_resp_valid", {31'd0, resp_valid}, {31'd0, m_valid});
            chk("mdl_resp_id",    {31'd0, resp_id},    {31'd0, m_id});
            chk("mdl_resp_o",     {16'd0, resp_o},     {16'd0, m_o});
            chk("mdl_resp_cout",  {31'd0, resp_cout},  {31'd0, m_cout});
        end
    end

    task automatic idle();
        req0_valid = 0; req1_valid = 0;
        req0_op = 0; req0_a = 0; req0_b = 0;
        req1_op = 0; req1_a = 0; req1_b = 0;
    endtask

    task automatic set_req(input logic id, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        if (id) begin
            req1_valid = 1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    // One operation from one requester, result checked against hand values after the edge.
    task automatic do_op(input string name, input logic id, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp_o, input logic exp_c);
        idle();
        resp_ready = 1;
        set_req(id, op, a, b);
        @(posedge clk); #1;
        idle();
        chk({name, "_valid"}, {31'd0, resp_valid}, 32'd1);
        chk({name, "_o"},     {16'd0, resp_o},     {16'd0, exp_o});
        chk({name, "_cout"},  {31'd0, resp_cout},  {31'd0, exp_c});
        chk({name, "_id"},    {31'd0, resp_id},    {31'd0, id});
    endtask

    task automatic pulse_reset();
        #1 reset = 1;
        @(posedge clk); #1 reset = 0;
    endtask

    logic        id_seq [4];
    logic [15:0] held_o;

    initial begin
        reset = 1; resp_ready = 0;
        idle();
        @(posedge clk); @(posedge clk); #1;
        reset = 0;
        chk_en = 1;
        chk("rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_id",    {31'd0, resp_id},    32'd0);
        chk("rst_o",     {16'd0, resp_o},     32'd0);
        chk("rst_cout",  {31'd0, resp_cout},  32'd0);

        // Directed ALU vectors with hand-computed results.
        do_op("add_3_4",    1'b0, 2'b10, 16'h0003, 16'h0004, 16'h0007, 1'b0);
        do_op("sub_borrow", 1'b1, 2'b11, 16'h0005, 16'h0007, 16'hFFFE, 1'b0);
        do_op("sub_nobor",  1'b1, 2'b11, 16'h0007, 16'h0005, 16'h0002, 1'b1);
        do_op("add_ovf",    1'b0, 2'b10, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        do_op("and_op",     1'b0, 2'b00, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0);
        do_op("or_op",      1'b1, 2'b01, 16'hF0F0, 16'hFF00, 16'hFFF0, 1'b0);
        do_op("sub_equal",  1'b0, 2'b11, 16'h1234, 16'h1234, 16'h0000, 1'b1);

        // Contention from a fresh reset: both valid every cycle.
        idle();
        pulse_reset();
        resp_ready = 1;
        set_req(1'b0, 2'b10, 16'h0100, 16'h0001);
        set_req(1'b1, 2'b10, 16'h0200, 16'h0002);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            id_seq[i] = resp_id;
            chk("cont_valid", {31'd0, resp_valid}, 32'd1);
        end
`ifdef ALU_ARB_RR_EN
        chk("cont_id0", {31'd0, id_seq[0]}, 32'd0);
        chk("cont_id1", {31'd0, id_seq[1]}, 32'd1);
        chk("cont_id2", {31'd0, id_seq[2]}, 32'd0);
        chk("cont_id3", {31'd0, id_seq[3]}, 32'd1);
`else
        for (int i = 0; i < 4; i++) chk("cont_id_fixed", {31'd0, id_seq[i]}, 32'd0);
        chk("cont_r1_low", {31'd0, req1_ready}, 32'd0);
`endif

        // Backpressure: result pending with resp_ready low for three cycles.
        idle();
        @(posedge clk); #1;
        resp_ready = 0;
        set_req(1'b0, 2'b10, 16'h0010, 16'h0020);
        @(posedge clk); #1;
        set_req(1'b0, 2'b10, 16'h0100, 16'h0001);
        held_o = 16'h0030;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("bp_r0",    {31'd0, req0_ready}, 32'd0);
            chk("bp_r1",    {31'd0, req1_ready}, 32'd0);
            chk("bp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_o",     {16'd0, resp_o},     {16'd0, held_o});
            @(posedge clk); #1;
        end
        resp_ready = 1;
        #3 chk("bp_release_r0", {31'd0, req0_ready}, 32'd1);
        @(posedge clk); #1;
        idle();
        chk("bp_new_valid", {31'd0, resp_valid}, 32'd1);
        chk("bp_new_o",     {16'd0, resp_o},     32'h0101);

        // Reset mid-operation: pending result dropped without a clock edge.
        resp_ready = 0;
        set_req(1'b0, 2'b00, 16'h00FF, 16'h0F0F);
        @(posedge clk); #1;
        set_req(1'b1, 2'b01, 16'h0001, 16'h0002);
        chk("mid_pending", {31'd0, resp_valid}, 32'd1);
        #1 reset = 1;
        #1 chk("mid_async_clear", {31'd0, resp_valid}, 32'd0);
        chk("mid_r0_in_reset", {31'd0, req0_ready}, 32'd0);
        @(posedge clk); #2;
        reset = 0;
        #2;
        chk("post_rst_r0", {31'd0, req0_ready}, 32'd1);
        chk("post_rst_r1", {31'd0, req1_ready}, 32'd0);
        @(posedge clk); #1;
        chk("post_rst_id",    {31'd0, resp_id},    32'd0);
        chk("post_rst_valid", {31'd0, resp_valid}, 32'd1);
        chk("post_rst_o",     {16'd0, resp_o},     32'h000F);

        idle();
        resp_ready = 1;
        repeat (3) @(posedge clk);
        #1 chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
